// File: rtl/control_unit_if.sv
// Decode bus between instruction fetch (master) and the control unit (slave).
interface control_unit_if #(
  parameter int unsigned InstrWidth = 16,
  parameter int unsigned AluOpWidth = 3
);
  logic [InstrWidth-1:0] instr;
  logic                  halted;
  logic                  reg_write_en;
  logic [AluOpWidth-1:0] alu_op;
  logic                  alu_src_imm;
  logic                  mem_read_en;
  logic                  mem_write_en;
  logic                  branch;
  logic                  jump;
  logic                  illegal;

  modport master (
    output instr,
    input  halted, reg_write_en, alu_op, alu_src_imm,
           mem_read_en, mem_write_en, branch, jump, illegal
  );

  modport slave (
    input  instr,
    output halted, reg_write_en, alu_op, alu_src_imm,
           mem_read_en, mem_write_en, branch, jump, illegal
  );
endinterface

// File: rtl/control_unit.sv
// Combinational instruction decoder for the little-computer datapath with a
// sticky halted status latch (the only clocked state).
module control_unit #(
  parameter int unsigned InstrWidth = 16,
  parameter int unsigned AluOpWidth = 3
) (
  input logic           clk,
  input logic           rst,
  control_unit_if.slave bus
);

  localparam int unsigned OpcodeWidth = 4;
  localparam int unsigned OpcodeLsb   = InstrWidth - OpcodeWidth;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_SLL   = 3'd5,
    ALU_SRL   = 3'd6,
    ALU_PASSB = 3'd7
  } alu_op_e;

  logic [InstrWidth-1:0]  instr_w;
  logic [OpcodeWidth-1:0] opcode;
  logic                   unused_operand_bits;

  assign instr_w             = bus.instr;
  assign opcode              = instr_w[InstrWidth-1:OpcodeLsb];
  assign unused_operand_bits = ^instr_w[OpcodeLsb-1:0];

  logic    dec_wen;
  alu_op_e dec_alu;
  logic    dec_imm;
  logic    dec_mrd;
  logic    dec_mwr;
  logic    dec_br;
  logic    dec_jmp;
  logic    dec_ill;
  logic    dec_halt;

  // Raw opcode decode; unmatched opcodes fall back to NOP.
  always_comb begin
    dec_wen  = 1'b0;
    dec_alu  = ALU_ADD;
    dec_imm  = 1'b0;
    dec_mrd  = 1'b0;
    dec_mwr  = 1'b0;
    dec_br   = 1'b0;
    dec_jmp  = 1'b0;
    dec_ill  = 1'b0;
    dec_halt = 1'b0;
    case (opcode)
      4'h1: begin dec_wen = 1'b1; dec_alu = ALU_ADD; end
      4'h2: begin dec_wen = 1'b1; dec_alu = ALU_SUB; end
      4'h3: begin dec_wen = 1'b1; dec_alu = ALU_AND; end
      4'h4: begin dec_wen = 1'b1; dec_alu = ALU_OR;  end
      4'h5: begin dec_wen = 1'b1; dec_alu = ALU_XOR; end
      4'h6: begin dec_wen = 1'b1; dec_alu = ALU_SLL; end
      4'h7: begin dec_wen = 1'b1; dec_alu = ALU_SRL; end
      4'h8: begin dec_wen = 1'b1; dec_imm = 1'b1; end
      4'h9: begin dec_wen = 1'b1; dec_alu = ALU_PASSB; dec_imm = 1'b1; end
      4'hA: begin dec_wen = 1'b1; dec_imm = 1'b1; dec_mrd = 1'b1; end
      4'hB: begin dec_imm = 1'b1; dec_mwr = 1'b1; end
      4'hC: begin dec_alu = ALU_SUB; dec_br = 1'b1; end
      4'hD: dec_jmp  = 1'b1;
      4'hE: dec_ill  = 1'b1;
      4'hF: dec_halt = 1'b1;
      default: ;
    endcase
  end

  logic halt_q;
  logic halt_d;
  logic halted_raw;
  logic live;

  assign halt_d     = halt_q | dec_halt;
  assign halted_raw = dec_halt | halt_q;
  // Side-effecting strobes are only allowed out of reset and while not halted.
  assign live       = ~rst & ~halted_raw;

  // Sticky halt latch; reset has priority over a HALT in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end

  assign bus.halted       = ~rst & halted_raw;
  assign bus.reg_write_en = live & dec_wen;
  assign bus.alu_op       = AluOpWidth'(dec_alu);
  assign bus.alu_src_imm  = dec_imm;
  assign bus.mem_read_en  = live & dec_mrd;
  assign bus.mem_write_en = live & dec_mwr;
  assign bus.branch       = live & dec_br;
  assign bus.jump         = live & dec_jmp;
  assign bus.illegal      = ~rst & dec_ill;

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: expected decode pushed on drive,
// popped and checked mid-cycle.
module tb_control_unit;

  typedef struct packed {
    logic       halted;
    logic       wen;
    logic [2:0] alu;
    logic       imm;
    logic       mrd;
    logic       mwr;
    logic       br;
    logic       jmp;
    logic       ill;
  } exp_t;

  logic clk;
  logic rst;

  control_unit_if #(.InstrWidth(16), .AluOpWidth(3)) bus ();

  control_unit #(.InstrWidth(16), .AluOpWidth(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;
  bit   model_halt = 1'b0;

  // Reference decode table written directly from the opcode list.
  function automatic exp_t ref_decode(input logic r, input logic [15:0] ins, input bit hq);
    exp_t e;
    logic [3:0] op;
    bit hd;
    op = ins[15:12];
    e  = '0;
    case (op)
      4'h0: ;
      4'h1: e.wen = 1;
      4'h2: begin e.wen = 1; e.alu = 3'd1; end
      4'h3: begin e.wen = 1; e.alu = 3'd2; end
      4'h4: begin e.wen = 1; e.alu = 3'd3; end
      4'h5: begin e.wen = 1; e.alu = 3'd4; end
      4'h6: begin e.wen = 1; e.alu = 3'd5; end
      4'h7: begin e.wen = 1; e.alu = 3'd6; end
      4'h8: begin e.wen = 1; e.imm = 1; end
      4'h9: begin e.wen = 1; e.alu = 3'd7; e.imm = 1; end
      4'hA: begin e.wen = 1; e.imm = 1; e.mrd = 1; end
      4'hB: begin e.imm = 1; e.mwr = 1; end
      4'hC: begin e.alu = 3'd1; e.br = 1; end
      4'hD: e.jmp = 1;
      4'hE: e.ill = 1;
      default: ;
    endcase
    hd = (op == 4'hF) || hq;
    e.halted = hd;
    if (hd) begin
      e.wen = 0; e.mrd = 0; e.mwr = 0; e.br = 0; e.jmp = 0;
    end
    if (r) begin
      e.halted = 0; e.wen = 0; e.mrd = 0; e.mwr = 0;
      e.br = 0; e.jmp = 0; e.ill = 0;
    end
    return e;
  endfunction

  // Drive one cycle, check the popped expectation at the falling edge, then
  // advance the bench halt model across the rising edge.
  task automatic step(input string tag, input logic r, input logic [15:0] ins);
    exp_t e;
    exp_t obs;
    rst       = r;
    bus.instr = ins;
    exp_q.push_back(ref_decode(r, ins, model_halt));
    @(negedge clk);
    obs = {bus.halted, bus.reg_write_en, bus.alu_op, bus.alu_src_imm,
           bus.mem_read_en, bus.mem_write_en, bus.branch, bus.jump, bus.illegal};
    e = exp_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_fails++;
      $error("FAIL %s: instr=%h rst=%0b observed=%b expected=%b (halted,wen,alu[3],imm,mrd,mwr,br,jmp,ill)",
             tag, ins, r, obs, e);
    end
    @(posedge clk);
    if (r) model_halt = 1'b0;
    else if (ins[15:12] == 4'hF) model_halt = 1'b1;
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    bus.instr = 16'h0000;
    @(posedge clk);
    #1;
    step("reset_state", 1'b1, 16'h1000);
    step("halt_same_cycle", 1'b0, 16'hF000);
    step("halt_sticky_add", 1'b0, 16'h1000);
    step("halt_sticky_sw", 1'b0, 16'hB777);
    step("rst_while_halted", 1'b1, 16'h1000);
    step("add_after_rst", 1'b0, 16'h1000);
    step("sub_decode", 1'b0, 16'h2ABC);
    for (int op = 0; op < 15; op++) begin
      logic [15:0] ins;
      ins = {4'(op), 12'($urandom_range(0, 4095))};
      step($sformatf("sweep_op%0h", op), 1'b0, ins);
    end
    step("lw_decode", 1'b0, 16'hA123);
    step("beq_decode", 1'b0, 16'hC456);
    step("illegal_in_rst", 1'b1, 16'hE001);
    step("jmp_in_rst", 1'b1, 16'hD00F);
    step("halt_again", 1'b0, 16'hF0F0);
    step("halted_lui", 1'b0, 16'h9FFF);
    step("rst_and_halt", 1'b1, 16'hF000);
    step("after_rst_halt", 1'b0, 16'h1000);
    step("illegal_not_halted", 1'b0, 16'hE000);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fails++;
      $display("FAIL scoreboard_drain: observed %0d leftover expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no completion expected completion");
    $fatal(1);
  end

endmodule

// File: doc/control_unit.md
# control_unit

Instruction decoder for the single-cycle little-computer datapath. Takes the current 16-bit instruction and produces the register-file write enable, ALU operation and memory/branch strobes. Also maintains the processor-wide halted status, which becomes sticky once a HALT is decoded. Sits between instruction fetch and the datapath; all decode is combinational, and only the halt latch is clocked.

## Interface
Parameters:
- `InstrWidth`, 16: instruction width (from defs.svh).
- `AluOpWidth`, 3: ALU op code width (from defs.svh).

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst`  input  1  reset; one clock, reset is synchronous and active-high.
- `instr`  input  InstrWidth  current instruction; opcode = `instr[15:12]`, `instr[11:0]` ignored by this block.
- `halted`  output  1  processor halted.
- `reg_write_en`  output  1  register-file write enable.
- `alu_op`  output  AluOpWidth  ALU operation select.
- `alu_src_imm`  output  1  ALU B operand from immediate.
- `mem_read_en`  output  1  data memory read.
- `mem_write_en`  output  1  data memory write.
- `branch`  output  1  conditional branch (BEQ).
- `jump`  output  1  unconditional jump.
- `illegal`  output  1  reserved opcode decoded.

## Operation
ALU op encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, PASSB=7.

Opcode decode (`reg_write_en`, `alu_op`, other strobes; unlisted strobes are 0):
- 0x0 NOP: wen 0, ADD.
- 0x1 ADD: wen 1, ADD.
- 0x2 SUB: wen 1, SUB.
- 0x3 AND: wen 1, AND.
- 0x4 OR: wen 1, OR.
- 0x5 XOR: wen 1, XOR.
- 0x6 SLL: wen 1, SLL.
- 0x7 SRL: wen 1, SRL.
- 0x8 ADDI: wen 1, ADD, alu_src_imm.
- 0x9 LUI: wen 1, PASSB, alu_src_imm.
- 0xA LW: wen 1, ADD, alu_src_imm, mem_read_en.
- 0xB SW: wen 0, ADD, alu_src_imm, mem_write_en.
- 0xC BEQ: wen 0, SUB, branch.
- 0xD JMP: wen 0, ADD, jump.
- 0xE reserved: wen 0, ADD, illegal=1. Otherwise treated as NOP.
- 0xF HALT: wen 0, ADD, halt decoded.

Halt behaviour:
- Internal `halt_q` flop. Set on a clock edge when opcode = HALT and rst = 0. Cleared only by rst.
- `halted` = (opcode == HALT) | halt_q. It asserts combinationally in the same cycle HALT is presented, then stays high.
- While halted = 1: reg_write_en, mem_read_en, mem_write_en, branch and jump are forced 0. alu_op still follows decode.

Reset behaviour:
- While rst = 1, halted, reg_write_en, mem_read_en, mem_write_en, branch, jump and illegal are forced 0.
- alu_op and alu_src_imm follow decode during reset.
- rst = 1 at an edge clears halt_q.
- rst and HALT in the same cycle: rst wins, and halt_q = 0 after the edge.

Undriven/X opcode bits: no requirement; decode default (NOP) for any unmatched value.

## Timing
- All outputs except the halt_q contribution are combinational from `instr`, with zero cycle latency.
- halt_q is a one-cycle registered update. After HALT is removed from `instr`, halted remains 1 on all following cycles until a reset edge.
- halt_q reset value is 0. After a reset edge with a non-HALT instr, every output strobe is 0 except as decoded.

## Test plan
- rst 1 cycle, then instr = {0xF,12'h0}: halted = 1 and reg_write_en = 0 in the same cycle. After the edge, instr = {0x1,12'h0}: halted stays 1 and reg_write_en = 0.
- After reset, instr = {0x1,12'h0}: halted = 0, reg_write_en = 1, alu_op = 0. Then instr = 0x2xxx: alu_op = 1, wen 1.
- Sweep opcodes 0x0–0xE without HALT: each output matches the decode list. 0xB gives mem_write_en = 1 and wen 0. 0xE gives illegal = 1.
- Halted sticky, then assert rst for one edge with instr = 0x1000: halted = 0 and reg_write_en = 1 after rst drops.
- rst = 1 with instr = 0xF000 across an edge, then instr = 0x1000 with rst = 0: halted = 0 and wen 1.
- instr = 0xAxxx: wen 1, mem_read_en 1, alu_src_imm 1, alu_op 0. instr = 0xCxxx: branch 1, alu_op 1, wen 0.
